// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage: two-entry skid buffer with valid/ready on both sides,
// synchronous flush, and a saturating back-pressure cycle counter.
module ex_mem_skid_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned RSRC_W  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               valid_e,
    output logic               ready_e,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic [RSRC_W-1:0]  ResultSrcE,
    input  logic [XLEN-1:0]    ALUResultE,
    input  logic [XLEN-1:0]    WriteDataE,
    input  logic [XLEN-1:0]    PCPlus4E,
    input  logic [RADDR_W-1:0] RdE,
    input  logic               flush,
    output logic               valid_m,
    input  logic               ready_m,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic [RSRC_W-1:0]  ResultSrcM,
    output logic [XLEN-1:0]    ALUResultM,
    output logic [XLEN-1:0]    WriteDataM,
    output logic [XLEN-1:0]    PCPlus4M,
    output logic [RADDR_W-1:0] RdM,
    output logic [1:0]         occupancy,
    output logic [XLEN-1:0]    stall_cnt
);

    localparam int unsigned PW = 2 + RSRC_W + 3 * XLEN + RADDR_W;

    // State is fully described by the two entry valid bits {skid, head}.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StFull  = 2'b01,
        StSkid  = 2'b11
    } state_e;

    logic [PW-1:0]   in_pl;
    logic [PW-1:0]   head_d, head_q;
    logic [PW-1:0]   skid_d, skid_q;
    logic            head_valid_d, head_valid_q;
    logic            skid_valid_d, skid_valid_q;
    logic [XLEN-1:0] stall_cnt_d, stall_cnt_q;
    logic            head_rw, head_mw;
    logic            push, pop;
    state_e          state;

    assign in_pl = {RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE, PCPlus4E, RdE};
    assign {head_rw, head_mw, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM} = head_q;

    assign state = state_e'({skid_valid_q, head_valid_q});
    assign push  = valid_e & ready_e & ~flush;
    assign pop   = head_valid_q & ready_m;

    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_d       = head_q;
        skid_d       = skid_q;
        if (flush) begin
            // Payloads are left untouched; only the valid bits are squashed.
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (state)
                StEmpty: begin
                    if (push) begin
                        head_valid_d = 1'b1;
                        head_d       = in_pl;
                    end
                end
                StFull: begin
                    if (push && !pop) begin
                        skid_valid_d = 1'b1;
                        skid_d       = in_pl;
                    end else if (push && pop) begin
                        head_d = in_pl;
                    end else if (pop) begin
                        head_valid_d = 1'b0;
                    end
                end
                StSkid: begin
                    if (pop) begin
                        head_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    head_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid_q && !ready_m && (stall_cnt_q != {XLEN{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
            stall_cnt_q  <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ready_e   = ~skid_valid_q;
    assign valid_m   = head_valid_q;
    assign RegWriteM = head_rw & head_valid_q;
    assign MemWriteM = head_mw & head_valid_q;
    assign occupancy = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: FIFO scoreboard of pushed entries checked
// against the M-side outputs every cycle, plus a narrow instance for counter saturation.
module tb_ex_mem_skid_stage;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic        rw;
        logic        mw;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_e, ready_e, RegWriteE, MemWriteE, flush;
    logic [1:0]  ResultSrcE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        valid_m, ready_m, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM, occupancy;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, stall_cnt;
    logic [4:0]  RdM;

    logic        valid_e4, ready_e4, ready_m4, valid_m4, RegWriteM4, MemWriteM4;
    logic [1:0]  ResultSrcM4, occupancy4;
    logic [3:0]  ALUResultM4, WriteDataM4, PCPlus4M4, stall_cnt4;
    logic [4:0]  RdM4;

    int     vectors = 0;
    int     miscompares = 0;
    entry_t q[$];
    entry_t last_head;
    logic [31:0] stall_exp;

    always #5 clk = ~clk;

    ex_mem_skid_stage dut (
        .clk(clk), .reset_n(reset_n), .valid_e(valid_e), .ready_e(ready_e),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .RdE(RdE),
        .flush(flush), .valid_m(valid_m), .ready_m(ready_m), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    ex_mem_skid_stage #(.XLEN(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .valid_e(valid_e4), .ready_e(ready_e4),
        .RegWriteE(1'b1), .MemWriteE(1'b0), .ResultSrcE(2'd1),
        .ALUResultE(4'h9), .WriteDataE(4'h3), .PCPlus4E(4'h4), .RdE(5'd2),
        .flush(1'b0), .valid_m(valid_m4), .ready_m(ready_m4), .RegWriteM(RegWriteM4),
        .MemWriteM(MemWriteM4), .ResultSrcM(ResultSrcM4), .ALUResultM(ALUResultM4),
        .WriteDataM(WriteDataM4), .PCPlus4M(PCPlus4M4), .RdM(RdM4), .occupancy(occupancy4),
        .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic mw);
        valid_e    = v;
        ALUResultE = alu;
        WriteDataE = wd;
        PCPlus4E   = alu + 32'd4;
        RdE        = rd;
        ResultSrcE = rd[1:0];
        RegWriteE  = rw;
        MemWriteE  = mw;
    endtask

    task automatic check_state();
        entry_t h;
        chk("occupancy", occupancy, q.size());
        chk("valid_m", valid_m, q.size() != 0);
        chk("ready_e", ready_e, q.size() < 2);
        chk("stall_cnt", stall_cnt, stall_exp);
        if (q.size() != 0) begin
            h = q[0];
            chk("ALUResultM", ALUResultM, h.alu);
            chk("WriteDataM", WriteDataM, h.wd);
            chk("PCPlus4M", PCPlus4M, h.pc);
            chk("RdM", RdM, h.rd);
            chk("ResultSrcM", ResultSrcM, h.rs);
            chk("RegWriteM", RegWriteM, h.rw);
            chk("MemWriteM", MemWriteM, h.mw);
            last_head = h;
        end else begin
            chk("RegWriteM_idle", RegWriteM, 0);
            chk("MemWriteM_idle", MemWriteM, 0);
            chk("ALUResultM_hold", ALUResultM, last_head.alu);
            chk("WriteDataM_hold", WriteDataM, last_head.wd);
        end
    endtask

    // One clock: update the scoreboard from the pre-edge handshake, then check.
    task automatic step();
        entry_t cur;
        logic   push, pop, stall;
        push  = valid_e & ready_e & ~flush;
        pop   = valid_m & ready_m;
        stall = valid_m & ~ready_m;
        cur   = '{alu: ALUResultE, wd: WriteDataE, pc: PCPlus4E, rd: RdE, rs: ResultSrcE,
                  rw: RegWriteE, mw: MemWriteE};
        if (pop) begin
            if (q.size() == 0) chk("pop_from_empty", 1, 0);
            else void'(q.pop_front());
        end
        if (flush) q.delete();
        if (push) q.push_back(cur);
        if (stall && stall_exp != 32'hFFFF_FFFF) stall_exp++;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic model_reset();
        q.delete();
        stall_exp = '0;
        last_head = '{alu: 0, wd: 0, pc: 0, rd: 0, rs: 0, rw: 0, mw: 0};
    endtask

    initial begin
        reset_n  = 1'b0;
        flush    = 1'b0;
        ready_m  = 1'b0;
        valid_e4 = 1'b0;
        ready_m4 = 1'b1;
        drive(1'b1, 32'h55, 32'h66, 5'd3, 1'b1, 1'b0);
        model_reset();

        // Reset held with a valid writing instruction presented
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_valid_m", valid_m, 0);
            chk("rst_RegWriteM", RegWriteM, 0);
            chk("rst_occupancy", occupancy, 0);
            chk("rst_ready_e", ready_e, 1);
            chk("rst_stall_cnt", stall_cnt, 0);
        end
        reset_n = 1'b1;
        ready_m = 1'b1;
        step();
        chk("first_push_valid", valid_m, 1);

        // Streaming, including a bubble with all controls zero
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + i, 32'h100 + i, 5'(i + 1), i[0], i[1]);
            step();
            chk("stream_alu", ALUResultM, 32'h10 + i);
        end
        valid_e = 1'b0;
        step();
        step();

        // Back-pressure into the skid entry, then drain in order
        ready_m = 1'b0;
        drive(1'b1, 32'hA, 32'hAA, 5'd10, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hB, 32'hBB, 5'd11, 1'b1, 1'b1);
        step();
        chk("skid_ready_e", ready_e, 0);
        valid_e = 1'b0;
        repeat (4) step();
        chk("skid_occupancy", occupancy, 2);
        ready_m = 1'b1;
        step();
        chk("drain_B_head", ALUResultM, 32'hB);
        chk("drain_ready_e", ready_e, 1);
        step();

        // Flush from the skid state with a concurrent push attempt
        ready_m = 1'b0;
        drive(1'b1, 32'hC, 32'hCC, 5'd12, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hD, 32'hDD, 5'd13, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h77, 32'h70, 5'd7, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        valid_e = 1'b0;
        chk("flush_occupancy", occupancy, 0);
        repeat (2) begin
            step();
            chk("flush_no_rd7", valid_m && (RdM == 5'd7), 0);
        end

        // Flush from FULL: ready_e is high, push must still be discarded
        drive(1'b1, 32'hE, 32'hEE, 5'd14, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h77, 32'h70, 5'd7, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        valid_e = 1'b0;
        step();
        chk("flush_full_no_rd7", valid_m && (RdM == 5'd7), 0);

        // Gated store: MemWriteM for exactly one cycle, payload then holds
        ready_m = 1'b0;
        drive(1'b1, 32'h40, 32'hDEAD, 5'd4, 1'b0, 1'b1);
        step();
        valid_e = 1'b0;
        ready_m = 1'b1;
        chk("store_mw_on", MemWriteM, 1);
        step();
        chk("store_mw_off", MemWriteM, 0);
        chk("store_wd_hold", WriteDataM, 32'hDEAD);
        step();

        // Asynchronous reset while two entries are held
        ready_m = 1'b0;
        drive(1'b1, 32'h81, 32'h1, 5'd1, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h82, 32'h2, 5'd2, 1'b1, 1'b1);
        step();
        valid_e = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_valid_m", valid_m, 0);
        chk("midrst_RegWriteM", RegWriteM, 0);
        chk("midrst_MemWriteM", MemWriteM, 0);
        chk("midrst_ready_e", ready_e, 1);
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Counter saturation on the 4-bit instance
        ready_m4 = 1'b0;
        valid_e4 = 1'b1;
        @(posedge clk);
        #1;
        valid_e4 = 1'b0;
        chk("sat_valid_m", valid_m4, 1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            chk("sat_stall_cnt", stall_cnt4, (n > 15) ? 15 : n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
